// File: rtl/uno_dealer.sv
// -----------------------------------------------------------------------------
// uno_dealer
//   Draw-request sequencer that sits downstream of the card deck.
//   On i_start it pulses a deck shuffle, deals HAND_INIT cards round-robin to
//   NUM_PLAYERS hands, then flips the first non-wild card onto the discard
//   pile. In game it serves draw-1/2/4 requests for one player, fetching one
//   card at a time from the deck and writing each into hand storage.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               begin new game (shuffle + deal + flip)
//   i_req_valid           in-game draw request
//   i_req_count[2:0]      one-hot draw size: 001 / 010 / 100 = 1 / 2 / 4 cards
//   i_req_player[1:0]     recipient of the in-game draw
//   o_req_ready           high only while waiting for a request
//   i_deck_done           deck idle and ready for a command
//   i_deck_drawn          deck pulse: i_deck_card is valid this cycle
//   i_deck_card[5:0]      {color[1:0], value[3:0]}
//   o_deck_start          one-cycle shuffle command
//   o_deck_draw[2:0]      one-hot draw command (only 001 is ever issued)
//   o_hand_wr             one-cycle hand-storage write strobe
//   o_hand_player[1:0]    target player of o_hand_wr
//   o_hand_card[5:0]      card written (also shows a burned wild flip)
//   o_top_valid           discard top established
//   o_top_card[5:0]       initial discard top card
//   o_burn                one-cycle: flipped wild card rejected
//   o_busy                high in every state except IDLE, READY, ERROR
//   o_error               deck response timeout; cleared only by i_start
// -----------------------------------------------------------------------------
module uno_dealer #(
    parameter int NUM_PLAYERS = 4,
    parameter int HAND_INIT   = 7,
    parameter int TIMEOUT     = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_req_valid,
    input  logic [2:0] i_req_count,
    input  logic [1:0] i_req_player,
    output logic       o_req_ready,
    input  logic       i_deck_done,
    input  logic       i_deck_drawn,
    input  logic [5:0] i_deck_card,
    output logic       o_deck_start,
    output logic [2:0] o_deck_draw,
    output logic       o_hand_wr,
    output logic [1:0] o_hand_player,
    output logic [5:0] o_hand_card,
    output logic       o_top_valid,
    output logic [5:0] o_top_card,
    output logic       o_burn,
    output logic       o_busy,
    output logic       o_error
);

    // Deal counter covers up to 4 players x 15 cards = 60 writes.
    localparam int              CNT_W       = 6;
    localparam logic [CNT_W-1:0] DEAL_LAST  = CNT_W'(NUM_PLAYERS * HAND_INIT - 1);
    localparam logic [1:0]      PLAYER_LAST = 2'(NUM_PLAYERS - 1);
    localparam logic [7:0]      TIMER_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0]      DRAW_ONE    = 3'b001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SHUF,
        S_DEAL_REQ,
        S_DEAL_WAIT,
        S_FLIP_REQ,
        S_FLIP_WAIT,
        S_READY,
        S_DRAW_REQ,
        S_DRAW_WAIT,
        S_ERROR
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs (current / next pairs)
    // ------------------------------------------------------------------
    state_t           state_q,       state_d;
    logic [CNT_W-1:0] deal_cnt_q,    deal_cnt_d;
    logic [1:0]       deal_player_q, deal_player_d;
    logic [1:0]       draw_player_q, draw_player_d;
    logic [2:0]       remaining_q,   remaining_d;
    logic [7:0]       timer_q,       timer_d;

    logic             deck_start_q,  deck_start_d;
    logic [2:0]       deck_draw_q,   deck_draw_d;
    logic             hand_wr_q,     hand_wr_d;
    logic [1:0]       hand_player_q, hand_player_d;
    logic [5:0]       hand_card_q,   hand_card_d;
    logic             top_valid_q,   top_valid_d;
    logic [5:0]       top_card_q,    top_card_d;
    logic             burn_q,        burn_d;

    logic             start_game;
    logic             req_one_hot;
    logic             wait_expired;
    logic             flip_is_wild;

    // i_start is honoured only while the block is not mid-sequence.
    assign start_game   = i_start &&
                          (state_q == S_IDLE || state_q == S_READY || state_q == S_ERROR);
    assign req_one_hot  = (i_req_count == 3'b001) || (i_req_count == 3'b010) ||
                          (i_req_count == 3'b100);
    assign wait_expired = (timer_q == TIMER_LAST);
    // Values 13 and 14 are the two wild cards; they may not start the pile.
    assign flip_is_wild = (i_deck_card[3:0] == 4'd13) || (i_deck_card[3:0] == 4'd14);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch;
        // pulse outputs default low, held values default to their register.
        state_d       = state_q;
        deal_cnt_d    = deal_cnt_q;
        deal_player_d = deal_player_q;
        draw_player_d = draw_player_q;
        remaining_d   = remaining_q;
        timer_d       = timer_q;
        deck_start_d  = 1'b0;
        deck_draw_d   = 3'b000;
        hand_wr_d     = 1'b0;
        hand_player_d = hand_player_q;
        hand_card_d   = hand_card_q;
        top_valid_d   = top_valid_q;
        top_card_d    = top_card_q;
        burn_d        = 1'b0;

        if (start_game) begin
            // New game also wins over a simultaneous draw request in READY.
            deck_start_d  = 1'b1;
            top_valid_d   = 1'b0;
            deal_cnt_d    = '0;
            deal_player_d = '0;
            state_d       = S_SHUF;
        end else begin
            unique case (state_q)
                S_IDLE, S_ERROR: begin
                    // Leave only via i_start, handled above.
                end

                S_SHUF: begin
                    // The deck's done flag is stale in the cycle the shuffle
                    // command is on the wire, so ignore it until after.
                    if (!deck_start_q && i_deck_done) begin
                        state_d = S_DEAL_REQ;
                    end
                end

                S_DEAL_REQ, S_FLIP_REQ, S_DRAW_REQ: begin
                    if (i_deck_done) begin
                        deck_draw_d = DRAW_ONE;
                        timer_d     = '0;
                        unique case (state_q)
                            S_DEAL_REQ: state_d = S_DEAL_WAIT;
                            S_FLIP_REQ: state_d = S_FLIP_WAIT;
                            default:    state_d = S_DRAW_WAIT;
                        endcase
                    end
                end

                S_DEAL_WAIT: begin
                    if (i_deck_drawn) begin
                        hand_wr_d     = 1'b1;
                        hand_player_d = deal_player_q;
                        hand_card_d   = i_deck_card;
                        deal_player_d = (deal_player_q == PLAYER_LAST) ? 2'd0
                                                                       : deal_player_q + 2'd1;
                        deal_cnt_d    = deal_cnt_q + CNT_W'(1);
                        state_d       = (deal_cnt_q == DEAL_LAST) ? S_FLIP_REQ : S_DEAL_REQ;
                    end else if (wait_expired) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end

                S_FLIP_WAIT: begin
                    if (i_deck_drawn) begin
                        if (flip_is_wild) begin
                            burn_d      = 1'b1;
                            hand_card_d = i_deck_card;
                            state_d     = S_FLIP_REQ;
                        end else begin
                            top_card_d  = i_deck_card;
                            top_valid_d = 1'b1;
                            state_d     = S_READY;
                        end
                    end else if (wait_expired) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end

                S_READY: begin
                    // Malformed counts are dropped; the requester must retry.
                    if (i_req_valid && req_one_hot) begin
                        draw_player_d = i_req_player;
                        unique case (i_req_count)
                            3'b001:  remaining_d = 3'd1;
                            3'b010:  remaining_d = 3'd2;
                            default: remaining_d = 3'd4;
                        endcase
                        state_d = S_DRAW_REQ;
                    end
                end

                S_DRAW_WAIT: begin
                    if (i_deck_drawn) begin
                        hand_wr_d     = 1'b1;
                        hand_player_d = draw_player_q;
                        hand_card_d   = i_deck_card;
                        remaining_d   = remaining_q - 3'd1;
                        state_d       = (remaining_q == 3'd1) ? S_READY : S_DRAW_REQ;
                    end else if (wait_expired) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot. All state here
    // is plain flops (no memory arrays), so all of it is reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            deal_cnt_q    <= '0;
            deal_player_q <= '0;
            draw_player_q <= '0;
            remaining_q   <= '0;
            timer_q       <= '0;
            deck_start_q  <= 1'b0;
            deck_draw_q   <= 3'b000;
            hand_wr_q     <= 1'b0;
            hand_player_q <= '0;
            hand_card_q   <= '0;
            top_valid_q   <= 1'b0;
            top_card_q    <= '0;
            burn_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            deal_cnt_q    <= deal_cnt_d;
            deal_player_q <= deal_player_d;
            draw_player_q <= draw_player_d;
            remaining_q   <= remaining_d;
            timer_q       <= timer_d;
            deck_start_q  <= deck_start_d;
            deck_draw_q   <= deck_draw_d;
            hand_wr_q     <= hand_wr_d;
            hand_player_q <= hand_player_d;
            hand_card_q   <= hand_card_d;
            top_valid_q   <= top_valid_d;
            top_card_q    <= top_card_d;
            burn_q        <= burn_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_deck_start  = deck_start_q;
    assign o_deck_draw   = deck_draw_q;
    assign o_hand_wr     = hand_wr_q;
    assign o_hand_player = hand_player_q;
    assign o_hand_card   = hand_card_q;
    assign o_top_valid   = top_valid_q;
    assign o_top_card    = top_card_q;
    assign o_burn        = burn_q;

    // Status flags decode directly from the state register.
    assign o_req_ready   = (state_q == S_READY);
    assign o_error       = (state_q == S_ERROR);
    assign o_busy        = !(state_q == S_IDLE || state_q == S_READY || state_q == S_ERROR);

endmodule

// File: tb/tb_uno_dealer.sv
// -----------------------------------------------------------------------------
// tb_uno_dealer
//   Directed bench for uno_dealer. A small deck model answers each draw
//   command two cycles later, taking cards from a queue (or a non-wild
//   default generator when the queue is empty). A monitor logs hand writes,
//   burns and draw commands; the main sequence checks them against
//   hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uno_dealer;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_req_valid;
    logic [2:0] i_req_count;
    logic [1:0] i_req_player;
    logic       o_req_ready;
    logic       i_deck_done;
    logic       i_deck_drawn;
    logic [5:0] i_deck_card;
    logic       o_deck_start;
    logic [2:0] o_deck_draw;
    logic       o_hand_wr;
    logic [1:0] o_hand_player;
    logic [5:0] o_hand_card;
    logic       o_top_valid;
    logic [5:0] o_top_card;
    logic       o_burn;
    logic       o_busy;
    logic       o_error;

    uno_dealer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_req_valid  (i_req_valid),
        .i_req_count  (i_req_count),
        .i_req_player (i_req_player),
        .o_req_ready  (o_req_ready),
        .i_deck_done  (i_deck_done),
        .i_deck_drawn (i_deck_drawn),
        .i_deck_card  (i_deck_card),
        .o_deck_start (o_deck_start),
        .o_deck_draw  (o_deck_draw),
        .o_hand_wr    (o_hand_wr),
        .o_hand_player(o_hand_player),
        .o_hand_card  (o_hand_card),
        .o_top_valid  (o_top_valid),
        .o_top_card   (o_top_card),
        .o_burn       (o_burn),
        .o_busy       (o_busy),
        .o_error      (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Deck model state and monitor logs
    logic [5:0] card_q[$];
    logic [7:0] wr_log[$];     // {player, card}
    logic [5:0] burn_log[$];
    int         draw_cmds = 0;
    int         bad_draw  = 0;
    int         busy_bad  = 0;
    bit         deck_silent = 1'b0;
    bit         watch_busy  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Deck model: answers a draw command two cycles after seeing it.
    initial begin
        int pend;
        int gen_n;
        pend  = 0;
        gen_n = 0;
        i_deck_drawn = 1'b0;
        i_deck_card  = 6'd0;
        forever begin
            @(negedge clk);
            i_deck_drawn = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        i_deck_drawn = 1'b1;
                        if (card_q.size() > 0) begin
                            i_deck_card = card_q.pop_front();
                        end else begin
                            i_deck_card = {2'b01, 4'(gen_n % 10)};
                            gen_n++;
                        end
                    end
                end
                if (o_deck_draw == 3'b001 && !deck_silent) pend = 2;
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (o_hand_wr) wr_log.push_back({o_hand_player, o_hand_card});
            if (o_burn) burn_log.push_back(o_hand_card);
            if (o_deck_draw == 3'b001) draw_cmds++;
            else if (o_deck_draw != 3'b000) bad_draw++;
            if (watch_busy && !o_top_valid && !o_busy) busy_bad++;
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_req_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(o_req_ready), 32'd1);
        @(negedge clk);   // let the monitor log a write coincident with READY
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send_req(input logic [2:0] cnt, input logic [1:0] pl);
        i_req_valid  = 1'b1;
        i_req_count  = cnt;
        i_req_player = pl;
        @(negedge clk);
        i_req_valid  = 1'b0;
        i_req_count  = 3'b000;
    endtask

    // One in-game draw of n cards with values base, base+1, ...
    task automatic do_draw(input string tag, input logic [2:0] cnt, input logic [1:0] pl,
                           input int n, input logic [5:0] base);
        int s;
        int d;
        s = wr_log.size();
        d = draw_cmds;
        for (int i = 0; i < n; i++) card_q.push_back(base + 6'(i));
        send_req(cnt, pl);
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        wait_ready({tag, "_ready"}, 200);
        check({tag, "_writes"}, 32'(wr_log.size() - s), 32'(n));
        check({tag, "_draws"}, 32'(draw_cmds - d), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  32'((s + i < wr_log.size()) ? wr_log[s + i] : 8'hFF),
                  32'({pl, base + 6'(i)}));
        end
    endtask

    initial begin
        int s;
        int d;
        int n;
        int bad;
        logic [7:0] exp_w;

        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_req_valid  = 1'b0;
        i_req_count  = 3'b000;
        i_req_player = 2'd0;
        i_deck_done  = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        check("reset_outputs",
              32'({o_deck_start, o_deck_draw, o_hand_wr, o_hand_player, o_hand_card,
                   o_top_valid, o_top_card, o_burn, o_busy, o_error, o_req_ready}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_not_ready", 32'(o_req_ready), 32'd0);

        // ---------------- 1+2: deal and flip ----------------
        for (int k = 0; k < 28; k++) card_q.push_back({2'((k / 4) % 4), 4'(k % 10)});
        card_q.push_back(6'h0D);
        card_q.push_back(6'h2E);
        card_q.push_back(6'h15);
        pulse_start();
        check("t1_deck_start", 32'(o_deck_start), 32'd1);
        check("t1_busy", 32'(o_busy), 32'd1);
        watch_busy = 1'b1;
        @(negedge clk);
        check("t1_start_one_cycle", 32'(o_deck_start), 32'd0);
        wait_ready("t1_reach_ready", 1000);
        watch_busy = 1'b0;
        check("t1_write_count", 32'(wr_log.size()), 32'd28);
        bad = 0;
        for (int k = 0; k < 28; k++) begin
            exp_w = {2'(k % 4), 2'((k / 4) % 4), 4'(k % 10)};
            if (k >= wr_log.size() || wr_log[k] !== exp_w) bad++;
        end
        check("t1_deal_order", 32'(bad), 32'd0);
        check("t1_busy_throughout", 32'(busy_bad), 32'd0);
        check("t2_burn_count", 32'(burn_log.size()), 32'd2);
        check("t2_burn0", 32'((burn_log.size() > 0) ? burn_log[0] : 6'h3F), 32'h0D);
        check("t2_burn1", 32'((burn_log.size() > 1) ? burn_log[1] : 6'h3F), 32'h2E);
        check("t2_top_card", 32'(o_top_card), 32'h15);
        check("t2_top_valid", 32'(o_top_valid), 32'd1);
        check("t2_busy_low", 32'(o_busy), 32'd0);
        check("t1_draw_cmds", 32'(draw_cmds), 32'd31);

        // ---------------- 5: malformed requests ----------------
        d = draw_cmds;
        s = wr_log.size();
        send_req(3'b011, 2'd1);
        send_req(3'b000, 2'd1);
        repeat (8) @(negedge clk);
        check("t5_no_draw", 32'(draw_cmds - d), 32'd0);
        check("t5_no_write", 32'(wr_log.size() - s), 32'd0);
        check("t5_still_ready", 32'(o_req_ready), 32'd1);

        // ---------------- 3: draw-4/1/2 ----------------
        do_draw("t3_draw4", 3'b100, 2'd2, 4, 6'h31);
        do_draw("t3_draw1", 3'b001, 2'd0, 1, 6'h07);
        do_draw("t3_draw2", 3'b010, 2'd3, 2, 6'h28);
        check("t3_draw_only_001", 32'(bad_draw), 32'd0);

        // ---------------- 5b: start beats request ----------------
        s = wr_log.size();
        d = draw_cmds;
        i_start      = 1'b1;
        i_req_valid  = 1'b1;
        i_req_count  = 3'b001;
        i_req_player = 2'd1;
        @(negedge clk);
        i_start     = 1'b0;
        i_req_valid = 1'b0;
        i_req_count = 3'b000;
        check("t5_start_wins", 32'(o_deck_start), 32'd1);
        check("t5_top_cleared", 32'(o_top_valid), 32'd0);
        wait_ready("t5_redeal_ready", 1000);
        check("t5_redeal_writes", 32'(wr_log.size() - s), 32'd28);
        check("t5_redeal_draws", 32'(draw_cmds - d), 32'd29);

        // ---------------- 4: deck timeout ----------------
        deck_silent = 1'b1;
        send_req(3'b001, 2'd1);
        n = 0;
        while (o_deck_draw != 3'b001 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_draw_issued", 32'(o_deck_draw), 32'b001);
        n = 0;
        while (!o_error && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 32'd255);
        check("t4_error", 32'(o_error), 32'd1);
        check("t4_not_busy", 32'(o_busy), 32'd0);
        repeat (5) @(negedge clk);
        check("t4_error_sticky", 32'(o_error), 32'd1);
        deck_silent = 1'b0;
        pulse_start();
        check("t4_restart", 32'(o_deck_start), 32'd1);
        check("t4_error_cleared", 32'(o_error), 32'd0);
        wait_ready("t4_recover_ready", 1000);
        check("t4_top_valid", 32'(o_top_valid), 32'd1);

        // ---------------- 6: reset mid-deal ----------------
        s = wr_log.size();
        pulse_start();
        n = 0;
        while (wr_log.size() - s < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_ten_cards", 32'(wr_log.size() - s), 32'd10);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs",
              32'({o_deck_start, o_deck_draw, o_hand_wr, o_hand_player, o_hand_card,
                   o_top_valid, o_top_card, o_burn, o_busy, o_error, o_req_ready}), 32'd0);
        s = wr_log.size();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_no_write_after_reset", 32'(wr_log.size() - s), 32'd0);
        check("t6_idle", 32'(o_busy), 32'd0);
        pulse_start();
        wait_ready("t6_redeal_ready", 1000);
        check("t6_redeal_writes", 32'(wr_log.size() - s), 32'd28);
        bad = 0;
        for (int k = 0; k < 28; k++) begin
            if (s + k >= wr_log.size() || wr_log[s + k][7:6] !== 2'(k % 4)) bad++;
        end
        check("t6_rotation_from_p0", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
